// File: rtl/io_console_tx_pkg.sv
// -----------------------------------------------------------------------------
// io_console_tx_pkg
//  Shared constants, FSM state type and BCD helper functions for the debug
//  console transmitter (io_console_tx) and its binary-to-BCD converter.
//  No ports; imported by io_console_tx and bin2bcd_seq.
// -----------------------------------------------------------------------------
package io_console_tx_pkg;

  localparam int DATA_W     = 64;        // io_data width; BCD sizing assumes 64
  localparam int NDIG       = 20;        // 2^64-1 has 20 decimal digits
  localparam int BCD_W      = 4 * NDIG;
  localparam int IDX_W      = 5;         // holds digit index 0..NDIG-1
  localparam int FIFO_DEPTH = 4;         // captured values waiting for the converter

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_EMIT = 2'd2,
    ST_EOLS = 2'd3
  } state_t;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift the
  // whole BCD vector left by one, bringing in the next binary bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                    input logic            bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  // Index of the most-significant non-zero digit; 0 when the value is 0 so
  // that a lone '0' is printed.
  function automatic logic [IDX_W-1:0] msd_index(input logic [BCD_W-1:0] bcd);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Digit selected by a run-time index (mux written as a loop to keep widths
  // explicit).
  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] bcd,
                                          input logic [IDX_W-1:0] idx);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (IDX_W'(i) == idx) d = bcd[4*i +: 4];
    end
    return d;
  endfunction

endpackage

// File: rtl/io_console_tx_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//  Sequential shift-add-3 (double-dabble) converter, one bit per clock.
//  A start pulse loads the value; 64 iterations follow on the next 64 edges;
//  done rises on the last iteration edge and bcd then holds until the next
//  start.
// Ports
//  clk    in   1      clock
//  rst    in   1      synchronous active-high reset (abandons a conversion)
//  start  in   1      load bin and begin converting
//  bin    in   64     binary value
//  done   out  1      bcd is valid (held until next start)
//  bcd    out  80     20 packed BCD digits, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
import io_console_tx_pkg::*;

module bin2bcd_seq (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  logic [DATA_W-1:0] sh;
  logic [5:0]        cnt;
  logic              running;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh      <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else if (start) begin
      sh      <= bin;
      cnt     <= '0;
      running <= 1'b1;
      done    <= 1'b0;
      bcd     <= '0;
    end else if (running) begin
      bcd <= dabble_step(bcd, sh[DATA_W-1]);
      sh  <= {sh[DATA_W-2:0], 1'b0};
      cnt <= cnt + 6'd1;
      if (cnt == 6'd63) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_console_tx.sv
// -----------------------------------------------------------------------------
// io_console_tx
//  Consumer end of the CPU debug I/O port. Every 0->1 transition of io_write
//  captures io_data into a small FIFO. Each value is converted to unsigned
//  decimal ASCII (leading zeros suppressed) and streamed byte by byte,
//  followed by EOL, on a valid/ready byte interface.
// Ports
//  clk       in   1    clock, all state on posedge
//  rst       in   1    synchronous active-high reset
//  io_write  in   1    CPU I/O strobe (level); a rise means "new value"
//  io_data   in   64   value captured on the edge that sees the rise
//  tx_data   out  8    ASCII digit or EOL
//  tx_valid  out  1    tx_data holds a byte
//  tx_ready  in   1    sink accepts
//  busy      out  1    FSM not idle or FIFO non-empty
//  overflow  out  1    sticky: a value was dropped on a full FIFO
//
// Byte handshake: a byte transfers on a posedge where tx_valid & tx_ready.
// Once tx_valid is high, tx_valid and tx_data stay unchanged until that
// transfer happens; only rst can withdraw a pending byte.
// -----------------------------------------------------------------------------
import io_console_tx_pkg::*;

module io_console_tx #(
  parameter logic [7:0] EOL = EOL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_write,
  input  logic [DATA_W-1:0] io_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Edge detect and FIFO
  logic              prev;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic rise;
  logic pop;
  logic push_ok;
  logic xfer;

  // FSM
  state_t           state;
  logic [IDX_W-1:0] idx;

  // Converter
  logic             conv_done;
  logic [BCD_W-1:0] bcd;
  logic [IDX_W-1:0] msd;

  assign rise    = io_write & ~prev;
  assign pop     = (state == ST_IDLE) && (count != '0);
  // A full FIFO still accepts when the same edge pops a slot free.
  assign push_ok = rise && ((count != CNT_W'(FIFO_DEPTH)) || pop);
  assign xfer    = tx_valid & tx_ready;
  assign msd     = msd_index(bcd);
  assign busy    = (state != ST_IDLE) || (count != '0);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (pop),
    .bin   (mem[rd_ptr]),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // FIFO storage needs no reset: count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= io_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= io_write;
      if (rise && !push_ok) overflow <= 1'b1;
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Conversion / emission FSM. The converter starts on the IDLE pop edge;
  // the CONV state waits for done, then picks the first printed digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) state <= ST_CONV;
        end
        ST_CONV: begin
          if (conv_done) begin
            idx      <= msd;
            tx_data  <= ASCII_0 + {4'b0000, digit_at(bcd, msd)};
            tx_valid <= 1'b1;
            state    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            if (idx == '0) begin
              tx_data <= EOL;
              state   <= ST_EOLS;
            end else begin
              idx     <= idx - IDX_W'(1);
              tx_data <= ASCII_0 + {4'b0000, digit_at(bcd, idx - IDX_W'(1))};
            end
          end
        end
        ST_EOLS: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
